multi_thread_instruction_queue: RTL and testbench

//  Parametrised per-thread decoded-instruction queue between Decode and the Dynamic Scheduler.

---
 rtl/multi_thread_instruction_queue_pkg.sv | 32 +++
 rtl/multi_thread_instruction_queue_ib_thread_queue.sv | 87 ++++++++
 rtl/multi_thread_instruction_queue.sv | 64 ++++++
 tb/tb_multi_thread_instruction_queue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_thread_instruction_queue_pkg.sv
// Shared types for the per-thread decoded-instruction queue: thread ids,
// issue pipe selectors and the decoded-instruction record.
package multi_thread_instruction_queue_pkg;

  localparam int THREAD_NUMB_DEF = 4;
  localparam int PIPE_NUMB       = 4;
  localparam int THREAD_ID_W     = 2;
  localparam int DEPTH_DEF       = 8;

  typedef logic [THREAD_ID_W-1:0] thread_id_t;

  typedef enum logic [1:0] {
    PIPE_INT = 2'd0,
    PIPE_FP  = 2'd1,
    PIPE_MEM = 2'd2,
    PIPE_BR  = 2'd3
  } pipe_sel_t;

  typedef struct packed {
    thread_id_t  thread_id;
    pipe_sel_t   pipe_sel;
    logic [7:0]  opcode;
    logic [31:0] pc;
  } instruction_decoded_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [occ_width(DEPTH_DEF)-1:0] ib_occupancy_t;

endpackage

// File: rtl/multi_thread_instruction_queue_ib_thread_queue.sv
// One thread's circular instruction queue; full/empty are decided from the
// occupancy counter alone, and error flags are sticky until reset.
module ib_thread_queue
  import multi_thread_instruction_queue_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int AF_SLACK = 5,
  parameter int OCC_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enq_i,
  input  logic                 deq_i,
  input  logic                 flush_i,
  input  instruction_decoded_t wdata_i,
  output instruction_decoded_t head_o,
  output logic [OCC_W-1:0]     occupancy_o,
  output logic                 almost_full_o,
  output logic                 overflow_err_o,
  output logic                 underflow_err_o
);

  localparam int PTR_W = $clog2(DEPTH);

  instruction_decoded_t mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             empty_s, full_s, wr_s, rd_s;

  always_comb begin
    empty_s = (occ_q == OCC_W'(0));
    full_s  = (occ_q == OCC_W'(DEPTH));
    wr_s    = enq_i & ~flush_i & ~full_s;
    rd_s    = deq_i & ~flush_i & ~empty_s;
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (flush_i) begin
      head_d = PTR_W'(0);
      tail_d = PTR_W'(0);
      occ_d  = OCC_W'(0);
    end else begin
      if (wr_s) tail_d = tail_q + PTR_W'(1);
      if (rd_s) head_d = head_q + PTR_W'(1);
      if (wr_s && !rd_s) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (rd_s && !wr_s) begin
        occ_d = occ_q - OCC_W'(1);
      end else begin
        occ_d = occ_q;
      end
      // A full queue never reuses the slot freed by a same-cycle dequeue.
      ovf_d = ovf_q | (enq_i & full_s);
      udf_d = udf_q | (deq_i & empty_s);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= PTR_W'(0);
      tail_q <= PTR_W'(0);
      occ_q  <= OCC_W'(0);
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_s) mem_q[tail_q] <= wdata_i;
  end

  assign head_o          = mem_q[head_q];
  assign occupancy_o     = occ_q;
  assign almost_full_o   = (occ_q >= OCC_W'(DEPTH - AF_SLACK));
  assign overflow_err_o  = ovf_q;
  assign underflow_err_o = udf_q;

endmodule

// File: rtl/multi_thread_instruction_queue.sv
// Per-thread decoded-instruction queues between Decode and the scheduler:
// enqueue demux by thread id, rollback flush, and enable/stall issue gating.
module multi_thread_instruction_queue
  import multi_thread_instruction_queue_pkg::*;
#(
  parameter int  THREAD_NUMB = THREAD_NUMB_DEF,
  parameter int  DEPTH       = 8,
  parameter int  AF_SLACK    = 5,
  localparam int OCC_W       = $clog2(DEPTH + 1)
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        enable,
  input  logic                                        dec_valid,
  input  instruction_decoded_t                        dec_instr,
  input  logic [THREAD_NUMB-1:0]                      is_thread_scheduled_mask,
  input  logic [THREAD_NUMB-1:0]                      rb_valid,
  input  logic [THREAD_NUMB-1:0][PIPE_NUMB-1:0]       pipe_stall_mask,
  output logic [THREAD_NUMB-1:0]                      ib_fifo_full,
  output logic [THREAD_NUMB-1:0]                      ib_instructions_valid,
  output instruction_decoded_t [THREAD_NUMB-1:0]      ib_instructions,
  output logic [THREAD_NUMB-1:0][OCC_W-1:0]           ib_occupancy,
  output logic [THREAD_NUMB-1:0]                      ib_overflow_err,
  output logic [THREAD_NUMB-1:0]                      ib_underflow_err
);

  logic [THREAD_NUMB-1:0] enq_s, deq_s;

  for (genvar t = 0; t < THREAD_NUMB; t++) begin : g_thread
    assign enq_s[t] = dec_valid & (dec_instr.thread_id == thread_id_t'(t)) & ~rb_valid[t];
    assign deq_s[t] = is_thread_scheduled_mask[t] & ~rb_valid[t];

    ib_thread_queue #(
      .DEPTH    (DEPTH),
      .AF_SLACK (AF_SLACK),
      .OCC_W    (OCC_W)
    ) u_queue (
      .clk             (clk),
      .reset_n         (reset_n),
      .enq_i           (enq_s[t]),
      .deq_i           (deq_s[t]),
      .flush_i         (rb_valid[t]),
      .wdata_i         (dec_instr),
      .head_o          (ib_instructions[t]),
      .occupancy_o     (ib_occupancy[t]),
      .almost_full_o   (ib_fifo_full[t]),
      .overflow_err_o  (ib_overflow_err[t]),
      .underflow_err_o (ib_underflow_err[t])
    );
  end

  // Issue gating uses registered occupancy only, never the same-cycle dequeue.
  always_comb begin
    ib_instructions_valid = '0;
    for (int t = 0; t < THREAD_NUMB; t++) begin
      if (ib_occupancy[t] != OCC_W'(0)) begin
        ib_instructions_valid[t] = enable & ~pipe_stall_mask[t][ib_instructions[t].pipe_sel];
      end else begin
        ib_instructions_valid[t] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multi_thread_instruction_queue.sv
// Scoreboard bench: a per-thread queue model predicts head, occupancy,
// almost-full, valid gating and sticky error flags after every cycle.
module tb_multi_thread_instruction_queue;
  import multi_thread_instruction_queue_pkg::*;

  localparam int TN    = 4;
  localparam int DEPTH = 8;
  localparam int AF    = 5;
  localparam int OCC_W = 4;

  logic                          clk = 1'b0;
  logic                          reset_n;
  logic                          enable;
  logic                          dec_valid;
  instruction_decoded_t          dec_instr;
  logic [TN-1:0]                 is_thread_scheduled_mask;
  logic [TN-1:0]                 rb_valid;
  logic [TN-1:0][PIPE_NUMB-1:0]  pipe_stall_mask;
  logic [TN-1:0]                 ib_fifo_full;
  logic [TN-1:0]                 ib_instructions_valid;
  instruction_decoded_t [TN-1:0] ib_instructions;
  logic [TN-1:0][OCC_W-1:0]      ib_occupancy;
  logic [TN-1:0]                 ib_overflow_err;
  logic [TN-1:0]                 ib_underflow_err;

  multi_thread_instruction_queue #(.THREAD_NUMB(TN), .DEPTH(DEPTH), .AF_SLACK(AF)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .enable                   (enable),
    .dec_valid                (dec_valid),
    .dec_instr                (dec_instr),
    .is_thread_scheduled_mask (is_thread_scheduled_mask),
    .rb_valid                 (rb_valid),
    .pipe_stall_mask          (pipe_stall_mask),
    .ib_fifo_full             (ib_fifo_full),
    .ib_instructions_valid    (ib_instructions_valid),
    .ib_instructions          (ib_instructions),
    .ib_occupancy             (ib_occupancy),
    .ib_overflow_err          (ib_overflow_err),
    .ib_underflow_err         (ib_underflow_err)
  );

  always #5 clk = ~clk;

  instruction_decoded_t exp_q [TN][$];
  bit m_ovf [TN];
  bit m_udf [TN];
  int n_vec = 0;
  int n_err = 0;
  int seq   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instruction_decoded_t mk(input int tid, input pipe_sel_t p);
    instruction_decoded_t r;
    seq++;
    r.thread_id = thread_id_t'(tid);
    r.pipe_sel  = p;
    r.opcode    = 8'(seq * 3 + 1);
    r.pc        = 32'h1000 + 32'(seq * 4);
    return r;
  endfunction

  task automatic check_state();
    for (int t = 0; t < TN; t++) begin
      int sz;
      bit v;
      sz = exp_q[t].size();
      v  = (sz != 0) && enable && !pipe_stall_mask[t][exp_q[t][0].pipe_sel];
      check_val($sformatf("occ[%0d]", t), 64'(ib_occupancy[t]), 64'(sz));
      check_val($sformatf("afull[%0d]", t), 64'(ib_fifo_full[t]), 64'(sz >= DEPTH - AF));
      check_val($sformatf("ovf[%0d]", t), 64'(ib_overflow_err[t]), 64'(m_ovf[t]));
      check_val($sformatf("udf[%0d]", t), 64'(ib_underflow_err[t]), 64'(m_udf[t]));
      check_val($sformatf("valid[%0d]", t), 64'(ib_instructions_valid[t]), 64'(v));
      if (sz != 0) check_val($sformatf("head[%0d]", t), 64'(ib_instructions[t]), 64'(exp_q[t][0]));
    end
  endtask

  task automatic cycle(input bit dv, input instruction_decoded_t ins,
                       input logic [TN-1:0] sched, input logic [TN-1:0] rb);
    dec_valid = dv;
    dec_instr = ins;
    is_thread_scheduled_mask = sched;
    rb_valid = rb;
    for (int t = 0; t < TN; t++) begin
      int sz;
      sz = exp_q[t].size();
      if (rb[t]) begin
        exp_q[t].delete();
      end else begin
        if (sched[t]) begin
          if (sz == 0) m_udf[t] = 1'b1;
          else void'(exp_q[t].pop_front());
        end
        if (dv && int'(ins.thread_id) == t) begin
          if (sz == DEPTH) m_ovf[t] = 1'b1;
          else exp_q[t].push_back(ins);
        end
      end
    end
    @(posedge clk);
    #1;
    dec_valid = 1'b0;
    is_thread_scheduled_mask = '0;
    rb_valid = '0;
    #1;
    check_state();
  endtask

  task automatic enq(input int tid, input pipe_sel_t p);
    cycle(1'b1, mk(tid, p), '0, '0);
  endtask

  task automatic drain(input int tid);
    int n;
    n = exp_q[tid].size();
    repeat (n) cycle(1'b0, '0, TN'(1 << tid), '0);
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b1;
    dec_valid = 1'b0;
    dec_instr = '0;
    is_thread_scheduled_mask = '0;
    rb_valid = '0;
    pipe_stall_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    reset_n = 1'b1;

    // Reset mid-stream with three entries in T0
    repeat (3) enq(0, PIPE_INT);
    reset_n = 1'b0;
    for (int t = 0; t < TN; t++) begin
      exp_q[t].delete();
      m_ovf[t] = 1'b0;
      m_udf[t] = 1'b0;
    end
    @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    reset_n = 1'b1;

    // T1: almost-full at 3, fill to 8, overflow, full enq+deq, drain in order
    for (int i = 0; i < 9; i++) enq(1, pipe_sel_t'(i % 4));
    cycle(1'b1, mk(1, PIPE_FP), TN'(2), '0);
    drain(1);

    // Underflow on empty T1, flag persists
    cycle(1'b0, '0, TN'(2), '0);
    cycle(1'b0, '0, '0, '0);

    // Pointer wrap on T0 at occupancy 4
    for (int i = 0; i < 4; i++) enq(0, pipe_sel_t'(i % 4));
    for (int i = 0; i < 20; i++) cycle(1'b1, mk(0, pipe_sel_t'(i % 4)), TN'(1), '0);
    drain(0);

    // Flush priority on T2 with T3 untouched
    for (int i = 0; i < 5; i++) enq(2, PIPE_INT);
    for (int i = 0; i < 3; i++) enq(3, PIPE_FP);
    cycle(1'b1, mk(2, PIPE_BR), TN'(4), TN'(4));
    drain(3);

    // Stall mask and enable gating on T0
    pipe_stall_mask[0][PIPE_MEM] = 1'b1;
    enq(0, PIPE_MEM);
    pipe_stall_mask[0][PIPE_MEM] = 1'b0;
    #1;
    check_state();
    enable = 1'b0;
    #1;
    check_state();
    enable = 1'b1;
    drain(0);

    // Random mix
    for (int i = 0; i < 150; i++) begin
      int tid;
      tid = int'($urandom_range(0, TN - 1));
      pipe_stall_mask = TN*PIPE_NUMB'($urandom) & TN*PIPE_NUMB'($urandom);
      enable = ($urandom_range(0, 7) != 0);
      cycle($urandom_range(0, 3) != 0, mk(tid, pipe_sel_t'($urandom_range(0, 3))),
            TN'($urandom) & TN'($urandom),
            ($urandom_range(0, 15) == 0) ? TN'(1 << $urandom_range(0, TN - 1)) : TN'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
